// File: rtl/fpu_result_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fpu_result_arbiter
// Description : Round-robin collector of FPU unit results into a small FIFO,
//               with sticky exception-flag accumulation on writeback.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_result_arbiter #(
    parameter int N_UNITS = 4,
    parameter int DEPTH   = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic [N_UNITS-1:0]          valid_in,
    output logic [N_UNITS-1:0]          ready_out,
    input  logic [N_UNITS*32-1:0]       data_in,
    input  logic [N_UNITS*5-1:0]        flags_in,
    output logic                        valid_out,
    input  logic                        ready_in,
    output logic [31:0]                 result,
    output logic [4:0]                  result_flags,
    output logic [$clog2(N_UNITS)-1:0]  result_src,
    input  logic                        fflags_clr,
    output logic [4:0]                  fflags
);

    localparam int SRC_W = $clog2(N_UNITS);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [SRC_W-1:0] rr_ptr;

    logic [31:0]      mem_data  [DEPTH];
    logic [4:0]       mem_flags [DEPTH];
    logic [SRC_W-1:0] mem_src   [DEPTH];

    logic             pop;
    logic             push;
    logic             space;
    logic             found;
    logic [SRC_W-1:0] grant_idx;
    logic [SRC_W-1:0] next_rr;
    logic [SRC_W:0]   scan;

    assign valid_out = (count != '0);
    assign pop       = valid_out && ready_in;
    assign space     = (count < CNT_W'(DEPTH)) || pop;

    // Rotating scan: the first valid unit at or after rr_ptr wins.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        scan      = '0;
        for (int k = 0; k < N_UNITS; k++) begin
            scan = {1'b0, rr_ptr} + (SRC_W+1)'(k);
            if (scan >= (SRC_W+1)'(N_UNITS))
                scan = scan - (SRC_W+1)'(N_UNITS);
            if (!found && valid_in[scan[SRC_W-1:0]]) begin
                found     = 1'b1;
                grant_idx = scan[SRC_W-1:0];
            end
        end
    end

    assign push      = found && space && !flush && !reset;
    assign ready_out = push ? (N_UNITS'(1) << grant_idx) : '0;
    assign next_rr   = (grant_idx == SRC_W'(N_UNITS - 1)) ? '0 : grant_idx + SRC_W'(1);

    assign result       = valid_out ? mem_data[rd_ptr]  : '0;
    assign result_flags = valid_out ? mem_flags[rd_ptr] : '0;
    assign result_src   = valid_out ? mem_src[rd_ptr]   : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr]  <= data_in[grant_idx*32 +: 32];
            mem_flags[wr_ptr] <= flags_in[grant_idx*5 +: 5];
            mem_src[wr_ptr]   <= grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            rr_ptr <= '0;
            fflags <= '0;
        end else begin
            // A flag popped alongside a clear survives the clear.
            fflags <= (fflags_clr ? 5'b0 : fflags) | (pop ? result_flags : 5'b0);
            if (flush) begin
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
                rr_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                    rr_ptr <= next_rr;
                end
                if (pop)
                    rd_ptr <= rd_ptr + PTR_W'(1);
                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fpu_result_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_result_arbiter
// Description : Directed vector table plus randomized run against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_result_arbiter;

    localparam int N_UNITS = 4;
    localparam int DEPTH   = 2;

    logic                   clk;
    logic                   reset;
    logic                   flush;
    logic [N_UNITS-1:0]     valid_in;
    logic [N_UNITS-1:0]     ready_out;
    logic [N_UNITS*32-1:0]  data_in;
    logic [N_UNITS*5-1:0]   flags_in;
    logic                   valid_out;
    logic                   ready_in;
    logic [31:0]            result;
    logic [4:0]             result_flags;
    logic [1:0]             result_src;
    logic                   fflags_clr;
    logic [4:0]             fflags;

    fpu_result_arbiter #(.N_UNITS(N_UNITS), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .valid_in     (valid_in),
        .ready_out    (ready_out),
        .data_in      (data_in),
        .flags_in     (flags_in),
        .valid_out    (valid_out),
        .ready_in     (ready_in),
        .result       (result),
        .result_flags (result_flags),
        .result_src   (result_src),
        .fflags_clr   (fflags_clr),
        .fflags       (fflags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       fl;
        logic       clr;
        logic       rdy;
        logic [3:0] vin;
        logic [3:0] exp_ready;
        logic       exp_valid;
        logic [1:0] exp_src;
        logic [4:0] exp_ff;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  f;
        int          s;
    } ent_t;

    vec_t tbl [20];
    ent_t q [$];
    int   m_rr;
    logic [4:0] m_ff;
    int   n_vec;
    int   n_bad;

    function automatic logic [31:0] tbl_data(int u);
        return (u == 2) ? 32'h0000_0001 : 32'h0000_00A0 + 32'(u);
    endfunction

    function automatic logic [4:0] tbl_flags(int u);
        case (u)
            0:       return 5'b00001;
            1:       return 5'b00100;
            2:       return 5'b10000;
            default: return 5'b01000;
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // One clock: compare at negedge (model and optional table row), then advance model.
    task automatic step(int t);
        int   gidx;
        logic mv, mpop, mspace;
        logic [3:0]  er;
        logic [31:0] ed;
        logic [4:0]  ef;
        int          es;
        ent_t        e;
        @(negedge clk);
        mv     = (q.size() > 0);
        mpop   = mv && ready_in;
        mspace = (q.size() < DEPTH) || mpop;
        gidx   = -1;
        if (!reset && !flush && mspace)
            for (int k = 0; k < N_UNITS; k++)
                if (gidx < 0 && valid_in[(m_rr + k) % N_UNITS]) gidx = (m_rr + k) % N_UNITS;
        er = (gidx >= 0) ? 4'(1 << gidx) : 4'b0;
        ed = mv ? q[0].d : 32'h0;
        ef = mv ? q[0].f : 5'h0;
        es = mv ? q[0].s : 0;
        chk("ready_out",    32'(ready_out),    32'(er));
        chk("valid_out",    32'(valid_out),    32'(mv));
        chk("result",       result,            ed);
        chk("result_flags", 32'(result_flags), 32'(ef));
        chk("result_src",   32'(result_src),   32'(es));
        chk("fflags",       32'(fflags),       32'(m_ff));
        if (t >= 0) begin
            chk("tbl_ready",  32'(ready_out), 32'(tbl[t].exp_ready));
            chk("tbl_valid",  32'(valid_out), 32'(tbl[t].exp_valid));
            chk("tbl_src",    32'(result_src), 32'(tbl[t].exp_src));
            chk("tbl_fflags", 32'(fflags),    32'(tbl[t].exp_ff));
            chk("tbl_result", result, tbl[t].exp_valid ? tbl_data(int'(tbl[t].exp_src)) : 32'h0);
        end
        @(posedge clk);
        if (reset) begin
            q.delete();
            m_rr = 0;
            m_ff = '0;
        end else begin
            m_ff = (fflags_clr ? 5'b0 : m_ff) | (mpop ? q[0].f : 5'b0);
            if (flush) begin
                q.delete();
                m_rr = 0;
            end else begin
                if (mpop) void'(q.pop_front());
                if (gidx >= 0) begin
                    e.d = data_in[gidx*32 +: 32];
                    e.f = flags_in[gidx*5 +: 5];
                    e.s = gidx;
                    q.push_back(e);
                    m_rr = (gidx + 1) % N_UNITS;
                end
            end
        end
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        m_rr  = 0;
        m_ff  = '0;
        //            rst fl  clr rdy vin      exp_rdy  ev  src    fflags
        tbl[0]  = '{1'b0,1'b0,1'b0,1'b1,4'b0100,4'b0100,1'b0,2'd0,5'b00000};
        tbl[1]  = '{1'b0,1'b0,1'b0,1'b1,4'b0000,4'b0000,1'b1,2'd2,5'b00000};
        tbl[2]  = '{1'b1,1'b0,1'b0,1'b1,4'b1111,4'b0000,1'b0,2'd0,5'b10000};
        tbl[3]  = '{1'b0,1'b0,1'b0,1'b1,4'b1111,4'b0001,1'b0,2'd0,5'b00000};
        tbl[4]  = '{1'b0,1'b0,1'b0,1'b1,4'b1111,4'b0010,1'b1,2'd0,5'b00000};
        tbl[5]  = '{1'b0,1'b0,1'b0,1'b1,4'b1111,4'b0100,1'b1,2'd1,5'b00001};
        tbl[6]  = '{1'b0,1'b0,1'b0,1'b1,4'b1111,4'b1000,1'b1,2'd2,5'b00101};
        tbl[7]  = '{1'b0,1'b0,1'b0,1'b1,4'b1111,4'b0001,1'b1,2'd3,5'b10101};
        tbl[8]  = '{1'b0,1'b0,1'b1,1'b1,4'b0000,4'b0000,1'b1,2'd0,5'b11101};
        tbl[9]  = '{1'b0,1'b0,1'b0,1'b0,4'b0011,4'b0010,1'b0,2'd0,5'b00001};
        tbl[10] = '{1'b0,1'b0,1'b0,1'b0,4'b0011,4'b0001,1'b1,2'd1,5'b00001};
        tbl[11] = '{1'b0,1'b0,1'b0,1'b0,4'b0011,4'b0000,1'b1,2'd1,5'b00001};
        tbl[12] = '{1'b0,1'b0,1'b0,1'b0,4'b0011,4'b0000,1'b1,2'd1,5'b00001};
        tbl[13] = '{1'b0,1'b0,1'b0,1'b1,4'b0011,4'b0010,1'b1,2'd1,5'b00001};
        tbl[14] = '{1'b0,1'b0,1'b0,1'b1,4'b0000,4'b0000,1'b1,2'd0,5'b00101};
        tbl[15] = '{1'b0,1'b0,1'b0,1'b0,4'b1000,4'b1000,1'b1,2'd1,5'b00101};
        tbl[16] = '{1'b0,1'b1,1'b0,1'b0,4'b1111,4'b0000,1'b1,2'd1,5'b00101};
        tbl[17] = '{1'b0,1'b0,1'b0,1'b0,4'b0110,4'b0010,1'b0,2'd0,5'b00101};
        tbl[18] = '{1'b1,1'b0,1'b0,1'b0,4'b1111,4'b0000,1'b1,2'd1,5'b00101};
        tbl[19] = '{1'b0,1'b0,1'b0,1'b0,4'b0000,4'b0000,1'b0,2'd0,5'b00000};

        reset = 1'b1; flush = 1'b0; fflags_clr = 1'b0; ready_in = 1'b0;
        valid_in = '0;
        for (int u = 0; u < N_UNITS; u++) begin
            data_in[u*32 +: 32] = tbl_data(u);
            flags_in[u*5 +: 5]  = tbl_flags(u);
        end
        repeat (2) @(posedge clk);
        #1;

        for (int t = 0; t < 20; t++) begin
            reset      = tbl[t].rst;
            flush      = tbl[t].fl;
            fflags_clr = tbl[t].clr;
            ready_in   = tbl[t].rdy;
            valid_in   = tbl[t].vin;
            step(t);
        end

        // Exact clear/pop collision: sticky 00001, clear while popping 00100.
        reset = 1'b0; flush = 1'b0; fflags_clr = 1'b0; ready_in = 1'b1;
        valid_in = 4'b0001; step(-1);
        valid_in = 4'b0000; step(-1);
        valid_in = 4'b0010; step(-1);
        valid_in = 4'b0000; fflags_clr = 1'b1; step(-1);
        fflags_clr = 1'b0; step(-1);
        chk("clr_pop_collision", 32'(fflags), 32'(5'b00100));

        for (int c = 0; c < 1500; c++) begin
            reset      = ($urandom_range(199) == 0);
            flush      = ($urandom_range(49) == 0);
            fflags_clr = ($urandom_range(19) == 0);
            ready_in   = ($urandom_range(9) < 7);
            valid_in   = 4'($urandom);
            for (int u = 0; u < N_UNITS; u++) begin
                data_in[u*32 +: 32] = $urandom;
                flags_in[u*5 +: 5]  = 5'($urandom);
            end
            step(-1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
